// File: rtl/argmax_classifier_if.sv
// Logit-vector handshake and result bus between the network top level and the
// argmax decision stage.
interface argmax_classifier_if #(
    parameter int NUM_CLASSES = 10,
    parameter int DATA_W      = 16,
    parameter int IDX_W       = 4
);
    logic                     valid_in;
    logic signed [DATA_W-1:0] logits_in [0:NUM_CLASSES-1];
    logic                     busy;
    logic                     valid_out;
    logic [IDX_W-1:0]         class_out;
    logic signed [DATA_W-1:0] max_score;
    logic [DATA_W:0]          margin_out;
    logic                     overrun;

    modport master (
        output valid_in,
        output logits_in,
        input  busy,
        input  valid_out,
        input  class_out,
        input  max_score,
        input  margin_out,
        input  overrun
    );

    modport slave (
        input  valid_in,
        input  logits_in,
        output busy,
        output valid_out,
        output class_out,
        output max_score,
        output margin_out,
        output overrun
    );
endinterface

// File: rtl/argmax_classifier.sv
// Sequential argmax over a captured logit vector: one comparator, one class per
// cycle, reporting winning index, its score and the top-1/top-2 margin.
module argmax_classifier #(
    parameter int NUM_CLASSES = 10,
    parameter int DATA_W      = 16,
    parameter int IDX_W       = 4
) (
    input  logic               clk,
    input  logic               rstN,
    argmax_classifier_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [IDX_W-1:0]         LAST_IDX = IDX_W'(NUM_CLASSES - 1);
    localparam logic signed [DATA_W-1:0] MIN_VAL  = {1'b1, {(DATA_W-1){1'b0}}};

    state_e state_q, state_d;

    logic signed [DATA_W-1:0] buf_q [0:NUM_CLASSES-1];
    logic signed [DATA_W-1:0] buf_d [0:NUM_CLASSES-1];
    logic signed [DATA_W-1:0] best_q, best_d;
    logic signed [DATA_W-1:0] second_q, second_d;
    logic [IDX_W-1:0]         best_idx_q, best_idx_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic                     busy_q, busy_d;
    logic                     valid_out_q, valid_out_d;
    logic [IDX_W-1:0]         class_q, class_d;
    logic signed [DATA_W-1:0] max_score_q, max_score_d;
    logic [DATA_W:0]          margin_q, margin_d;
    logic                     overrun_q, overrun_d;

    logic                     accept_s;
    logic                     last_s;
    logic signed [DATA_W-1:0] cand_s;

    assign accept_s = bus.valid_in && (state_q == IDLE);
    assign last_s   = (state_q == SCAN) && (idx_q == LAST_IDX);
    assign cand_s   = buf_q[idx_q];

    // State register.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.valid_in) begin
                    state_d = SCAN;
                end else begin
                    state_d = IDLE;
                end
            end
            SCAN: begin
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    state_d = SCAN;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next values; results are latched on the final compare
    // so they appear registered during DONE.
    always_comb begin
        buf_d       = buf_q;
        best_d      = best_q;
        second_d    = second_q;
        best_idx_d  = best_idx_q;
        idx_d       = idx_q;
        class_d     = class_q;
        max_score_d = max_score_q;
        margin_d    = margin_q;

        if (accept_s) begin
            buf_d      = bus.logits_in;
            best_d     = bus.logits_in[0];
            best_idx_d = {IDX_W{1'b0}};
            second_d   = MIN_VAL;
            idx_d      = IDX_W'(1);
        end else if (state_q == SCAN) begin
            if (cand_s > best_q) begin
                second_d   = best_q;
                best_d     = cand_s;
                best_idx_d = idx_q;
            end else if (cand_s > second_q) begin
                second_d = cand_s;
            end else begin
                second_d = second_q;
            end
            idx_d = idx_q + IDX_W'(1);
        end else begin
            idx_d = idx_q;
        end

        if (last_s) begin
            class_d     = best_idx_d;
            max_score_d = best_d;
            margin_d    = {best_d[DATA_W-1], best_d} - {second_d[DATA_W-1], second_d};
        end else begin
            class_d     = class_q;
            max_score_d = max_score_q;
            margin_d    = margin_q;
        end

        valid_out_d = last_s;
        busy_d      = (state_d != IDLE);
        overrun_d   = overrun_q | (bus.valid_in && (state_q != IDLE));
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                buf_q[i] <= {DATA_W{1'b0}};
            end
            best_q      <= {DATA_W{1'b0}};
            second_q    <= {DATA_W{1'b0}};
            best_idx_q  <= {IDX_W{1'b0}};
            idx_q       <= {IDX_W{1'b0}};
            busy_q      <= 1'b0;
            valid_out_q <= 1'b0;
            class_q     <= {IDX_W{1'b0}};
            max_score_q <= {DATA_W{1'b0}};
            margin_q    <= {(DATA_W+1){1'b0}};
            overrun_q   <= 1'b0;
        end else begin
            buf_q       <= buf_d;
            best_q      <= best_d;
            second_q    <= second_d;
            best_idx_q  <= best_idx_d;
            idx_q       <= idx_d;
            busy_q      <= busy_d;
            valid_out_q <= valid_out_d;
            class_q     <= class_d;
            max_score_q <= max_score_d;
            margin_q    <= margin_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.valid_out  = valid_out_q;
    assign bus.class_out  = class_q;
    assign bus.max_score  = max_score_q;
    assign bus.margin_out = margin_q;
    assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_argmax_classifier.sv
// Directed and randomized bench for argmax_classifier against a two-pass
// max/second-max reference model.
module tb_argmax_classifier;

    localparam int N = 10;
    localparam int W = 16;

    typedef logic signed [W-1:0] vec_t [0:N-1];

    logic clk  = 1'b0;
    logic rstN = 1'b0;
    int   tests  = 0;
    int   failed = 0;
    int   ovr_exp = 0;

    argmax_classifier_if #(.NUM_CLASSES(N), .DATA_W(W), .IDX_W(4)) bus ();

    argmax_classifier #(.NUM_CLASSES(N), .DATA_W(W), .IDX_W(4)) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Best = first occurrence of the maximum; second = maximum of everything else.
    task automatic model(input vec_t v, output int cls, output int best, output int margin);
        int second;
        best = v[0];
        cls  = 0;
        for (int i = 1; i < N; i++) begin
            if (int'(v[i]) > best) begin
                best = v[i];
                cls  = i;
            end
        end
        second = -32768;
        for (int i = 0; i < N; i++) begin
            if (i != cls && int'(v[i]) > second) second = v[i];
        end
        margin = best - second;
    endtask

    task automatic scramble();
        for (int i = 0; i < N; i++) bus.logits_in[i] = W'($urandom);
    endtask

    // Called at a negedge: pulses valid_in this cycle (T) and checks T+1..T+11.
    task automatic send(input vec_t v, input string tag, input bit inj4, input bit inj10);
        int cls, best, margin;
        model(v, cls, best, margin);
        bus.valid_in  = 1'b1;
        bus.logits_in = v;
        for (int k = 1; k <= N + 1; k++) begin
            @(negedge clk);
            bus.valid_in = ((k == 4) && inj4) || ((k == N) && inj10);
            if (bus.valid_in) begin
                ovr_exp = 1;
                for (int i = 0; i < N; i++) bus.logits_in[i] = 16'sh7FFF;
            end else begin
                scramble();
            end
            check({tag, " busy"}, bus.busy, (k <= N) ? 1 : 0);
            check({tag, " valid_out"}, bus.valid_out, (k == N) ? 1 : 0);
            if (k >= N) begin
                check({tag, " class"}, bus.class_out, cls);
                check({tag, " score"}, bus.max_score, best);
                check({tag, " margin"}, bus.margin_out, margin);
            end
        end
        check({tag, " overrun"}, bus.overrun, ovr_exp);
    endtask

    initial begin
        vec_t v;
        int   r;

        bus.valid_in = 1'b0;
        for (int i = 0; i < N; i++) bus.logits_in[i] = 16'sd0;
        repeat (2) @(negedge clk);
        check("rst busy", bus.busy, 0);
        check("rst valid_out", bus.valid_out, 0);
        check("rst class", bus.class_out, 0);
        check("rst score", bus.max_score, 0);
        check("rst margin", bus.margin_out, 0);
        check("rst overrun", bus.overrun, 0);
        rstN = 1'b1;
        @(negedge clk);

        v = '{16'sd0, 16'sd5, -16'sd3, 16'sd12, 16'sd7, 16'sd1, 16'sd0, -16'sd8, 16'sd2, 16'sd11};
        send(v, "basic", 1'b0, 1'b0);
        check("basic const class", bus.class_out, 3);
        check("basic const margin", bus.margin_out, 1);

        v = '{-16'sd100, -16'sd20, -16'sd50, -16'sd20, -16'sd90,
              -16'sd30, -16'sd70, -16'sd60, -16'sd80, -16'sd40};
        send(v, "neg_tie", 1'b0, 1'b0);
        check("neg_tie const class", bus.class_out, 1);

        for (int i = 0; i < N; i++) v[i] = 16'sh8000;
        v[N-1] = 16'sh7FFF;
        send(v, "ext_hi", 1'b0, 1'b0);
        check("ext_hi const margin", bus.margin_out, 65535);

        for (int i = 0; i < N; i++) v[i] = 16'sh8000;
        v[0] = 16'sh7FFF;
        send(v, "ext_lo", 1'b0, 1'b0);
        check("ext_lo const class", bus.class_out, 0);

        v = '{16'sd4, -16'sd9, 16'sd30, 16'sd2, 16'sd29, 16'sd0, 16'sd1, 16'sd3, -16'sd1, 16'sd5};
        send(v, "ovr", 1'b1, 1'b1);
        v = '{16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd5, 16'sd6, 16'sd7, 16'sd8, 16'sd9, 16'sd10};
        send(v, "after_ovr", 1'b0, 1'b0);

        // Abort mid-scan with reset.
        v = '{16'sd50, 16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd5, 16'sd6, 16'sd7, 16'sd8, 16'sd9};
        bus.valid_in  = 1'b1;
        bus.logits_in = v;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            bus.valid_in = 1'b0;
        end
        rstN = 1'b0;
        ovr_exp = 0;
        #1;
        check("abort busy", bus.busy, 0);
        check("abort valid_out", bus.valid_out, 0);
        check("abort class", bus.class_out, 0);
        check("abort score", bus.max_score, 0);
        check("abort margin", bus.margin_out, 0);
        check("abort overrun", bus.overrun, 0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 3) rstN = 1'b1;
            check("abort no valid_out", bus.valid_out, 0);
        end
        v = '{-16'sd5, 16'sd17, 16'sd3, 16'sd17, 16'sd9, 16'sd0, 16'sd16, 16'sd2, 16'sd1, 16'sd8};
        send(v, "post_abort", 1'b0, 1'b0);

        for (int t = 0; t < 24; t++) begin
            for (int i = 0; i < N; i++) begin
                if (t % 2 == 0) begin
                    r = $urandom_range(0, 7);
                    v[i] = W'(r - 4);
                end else begin
                    v[i] = W'($urandom);
                end
            end
            send(v, "rand", 1'b0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/argmax_classifier.md
Name: argmax_classifier

Overview:
- Final decision stage of the MNIST inference pipeline; sits directly downstream of the network top-level and consumes its 10 signed Q-format logits and valid pulse.
- Captures the logit vector, scans it sequentially with one comparator (one class per cycle) and reports the winning class index, its score and the top-1/top-2 margin.
- Margin is a confidence measure for the host.

Parameters:
- NUM_CLASSES, 10, number of logits to scan (must be >= 2).
- DATA_W, 16, signed logit width.
- IDX_W, 4, class index width (must be >= clog2(NUM_CLASSES)).

Ports:
- clk  in  1  system clock, rising edge.
- rstN  in  1  asynchronous active-low reset.
- valid_in  in  1  one-cycle pulse; logits_in is valid this cycle.
- logits_in  in  DATA_W x NUM_CLASSES (signed, unpacked [0:NUM_CLASSES-1])  logit vector.
- busy  out  1  high while a vector is held or being scanned (SCAN and DONE).
- valid_out  out  1  one-cycle pulse; result outputs updated this cycle.
- class_out  out  IDX_W  index of the maximum logit.
- max_score  out  DATA_W signed  value of the maximum logit.
- margin_out  out  DATA_W+1 unsigned  best minus second-best; no saturation needed.
- overrun  out  1  sticky flag: valid_in arrived while busy.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rstN.
- Reset values:
  - state = IDLE.
  - busy, valid_out, overrun = 0.
  - class_out, max_score, margin_out = 0.
  - Internal capture registers = 0.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - On valid_in, register the whole logits_in vector into a local buffer.
  - Set best = logit[0], best_idx = 0, second = -2^(DATA_W-1), idx = 1.
  - Go to SCAN.
- SCAN: each cycle compare buf[idx], signed.
  - If buf[idx] > best (strict): second <= best; best <= buf[idx]; best_idx <= idx.
  - Else if buf[idx] > second: second <= buf[idx].
  - idx increments each cycle; when idx == NUM_CLASSES-1 has been compared, go to DONE.
- Tie rule: the lowest index wins. An equal later value does not replace best but does update second, so margin = 0.
- DONE (one cycle):
  - valid_out = 1; class_out = best_idx; max_score = best; margin_out = best - second, computed in DATA_W+1 bits.
  - Return to IDLE.
- Latency: valid_in at cycle T, then valid_out at T+NUM_CLASSES (T+10 by default).
- busy is high at cycles T+1 .. T+NUM_CLASSES inclusive.
- A new valid_in is accepted only in IDLE, i.e. back-to-back throughput is one vector per NUM_CLASSES+1 cycles.
- valid_in while busy:
  - Vector is dropped; the scan in progress is unaffected.
  - overrun set to 1 and held until rstN.
- valid_in in the same cycle as valid_out (DONE) counts as busy and is dropped with overrun.
- class_out, max_score and margin_out hold their last values between results; they change only on valid_out cycles.
- logits_in is don't-care except in the valid_in cycle while IDLE; the buffer isolates the scan from upstream changes.
- Reset asserted mid-scan:
  - All state clears immediately; no valid_out is issued for the aborted vector.
  - First valid_in after rstN deassertion is accepted normally.
- Arithmetic: all comparisons are signed two's complement.
  - Extreme case: best = 32767, second = -32768 gives margin_out = 65535 (17-bit).

Test Plan:
- Reset then logits {0,5,-3,12,7,1,0,-8,2,11}, valid_in pulse at T -> valid_out only at T+10, class_out=3, max_score=12, margin_out=1, busy high T+1..T+10.
- All-negative logits {-100,-20,-50,-20,-90,-30,-70,-60,-80,-40} -> class_out=1 (lowest-index tie), max_score=-20, margin_out=0.
- Extremes: logit[9]=32767, all others -32768 -> class_out=9, max_score=32767, margin_out=65535; logit[0]=32767, others -32768 -> class_out=0.
- Second valid_in at T+4 and at T+10 -> first result unaffected (class and score as vector 1), both extra pulses dropped, overrun=1 and sticky; next valid_in at T+11 is accepted, result at T+21.
- rstN low at T+5 mid-scan -> no valid_out, all outputs 0, overrun 0; fresh vector after release gives correct result 10 cycles later.
- Upstream changes logits_in on cycles after the valid_in capture -> result reflects only the captured vector.
